icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 CLK  input  1  system clock, rising-edge active.
REQ-002 nRST  input  1  reset, asynchronous, active-low.
REQ-003 imemREN  input  1  datapath instruction read request.
REQ-004 imemaddr  input  32  datapath instruction byte address (the PC).
REQ-005 ihit  output  1  requested word valid this cycle; datapath advances the PC on it.
REQ-006 imemload  output  32  instruction word returned to the datapath.
REQ-007 iREN  output  1  read request to the memory controller.
REQ-008 iaddr  output  32  word-aligned fill address to the memory controller.
REQ-009 iwait  input  1  memory controller busy; low = iload valid.
REQ-010 iload  input  32  fill data from the memory controller.
REQ-011 hit_count  output  32  number of cycles with ihit=1.
REQ-012 miss_count  output  32  number of misses (fill starts).

Function
REQ-013 Direct-mapped, 16 frames, one 32-bit word per frame, read-only.
REQ-014 Address split: tag=addr[31:6] (26 b), idx=addr[5:2] (4 b), byte offset addr[1:0] ignored.
REQ-015 Frame contents: valid (1 b), tag (26 b), data (32 b).
REQ-016 Hit: imemREN & frame[idx].valid & (frame[idx].tag == tag), in state IDLE only.
REQ-017 ihit is combinational, same cycle as the request; zero-latency hit.
REQ-018 imemload = frame[idx].data when ihit=1, else 32'h0.
REQ-019 FSM states: IDLE, FETCH.
REQ-020 IDLE -> FETCH when imemREN=1 and not hit; miss address latched into a 30-bit register (addr[31:2]) on that edge.
REQ-021 FETCH: iREN=1, iaddr={latched[29:0],2'b00}, ihit=0.
REQ-022 FETCH with iwait=1: hold state, iREN, and iaddr.
REQ-023 FETCH with iwait=0: write the latched idx frame (valid=1, latched tag, data=iload) on that edge; go to IDLE.
REQ-024 After a fill, the replayed request hits in the first IDLE cycle: miss-to-ihit latency = memory latency + 1 cycle.
REQ-025 IDLE: iREN=0, iaddr=32'h0.
REQ-026 imemREN deasserted or imemaddr changed during FETCH: fill still completes to the latched address (no abort); then return to IDLE.
REQ-027 imemREN=0 in IDLE: ihit=0, no state change, no counter change.
REQ-028 Conflicting tag at the same idx: the fill overwrites the frame unconditionally (no write-back; read-only cache).
REQ-029 hit_count += 1 on every edge where ihit=1; saturates at 32'hFFFFFFFF.
REQ-030 miss_count += 1 on every IDLE->FETCH edge; saturates at 32'hFFFFFFFF.

Reset
REQ-031 nRST low, asynchronous: all 16 valid bits cleared, state=IDLE, latched address=0, hit_count=0, miss_count=0.
REQ-032 Outputs during reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-033 Reset mid-FETCH abandons the fill; no frame is written.
REQ-034 Frame tag/data fields need not be reset; valid=0 masks them.

Structure
REQ-035 cpu_types_pkg holds: icachef_t (packed tag/idx/bytoff struct), icache_frame_t (valid/tag/data), constants ITAG_W=26, IIDX_W=4, IFRAMES=16.
REQ-036 FSM state enum is local to the module.
REQ-037 Single module, no sub-module; frame array inferred as registers.
REQ-038 The module connects to the datapath_cache_if cache-side and caches_if cache-side modports through a top-level wrapper.

Verification
REQ-039 Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait low after 2 cycles with iload=0x0050_0093 -> iREN with iaddr=0x40 for 3 cycles; ihit=1 and imemload=0x0050_0093 on the next cycle; miss_count=1, hit_count=1.
REQ-040 Hit: repeat addr 0x0000_0042 -> ihit same cycle, imemload=0x0050_0093, iREN=0; hit_count increments.
REQ-041 Conflict: fill 0x40, then request 0x0000_0080 (same idx 0, different tag) -> miss and refill; a later request to 0x40 misses again; miss_count=3.
REQ-042 Address change mid-FETCH: miss on 0x44, switch imemaddr to 0x48 while iwait=1 -> iaddr stays 0x44; frame 1 filled; 0x48 then misses.
REQ-043 Reset mid-FETCH: assert nRST during FETCH -> iREN=0 immediately; after release, the same address misses again and the counters read 0.
REQ-044 Idle: imemREN=0 for 10 cycles -> ihit=0, iREN=0, counters unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: instruction-cache address split, frame layout and geometry.
package cpu_types_pkg;

    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IFRAMES = 16;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 16 one-word frames, zero-latency hits,
// blocking single-word fill from the memory controller on a miss.
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_q, state_d;
    logic [29:0]         miss_addr_q, miss_addr_d;
    logic [IFRAMES-1:0]  valid_q, valid_d;
    logic [ITAG_W-1:0]   tag_q [IFRAMES];
    logic [31:0]         data_q [IFRAMES];
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    icachef_t            req;
    icachef_t            fill;
    icache_frame_t       sel_frame;
    logic                lookup_hit;
    logic                fill_en;
    logic                unused_bytoff;

    assign req  = icachef_t'(imemaddr);
    assign fill = icachef_t'({miss_addr_q, 2'b00});
    assign unused_bytoff = ^{req.bytoff, fill.bytoff};

    always_comb begin
        sel_frame    = {valid_q[req.idx], tag_q[req.idx], data_q[req.idx]};
        lookup_hit   = (state_q == IDLE) && imemREN && sel_frame.valid
                       && (sel_frame.tag == req.tag);
        fill_en      = (state_q == FETCH) && !iwait;
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        case (state_q)
            IDLE: begin
                if (imemREN && !lookup_hit) begin
                    state_d     = FETCH;
                    miss_addr_d = imemaddr[31:2];
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end
            end
            FETCH: begin
                // The fill always targets the latched address, whatever the datapath does now.
                if (!iwait) begin
                    state_d           = IDLE;
                    valid_d[fill.idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (lookup_hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tag/data are masked by the valid bits, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[fill.idx]  <= fill.tag;
            data_q[fill.idx] <= iload;
        end
    end

    assign ihit       = lookup_hit;
    assign imemload   = lookup_hit ? sel_frame.data : 32'h0;
    assign iREN       = (state_q == FETCH);
    assign iaddr      = (state_q == FETCH) ? {miss_addr_q, 2'b00} : 32'h0;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, reset/idle sequences,
// then randomized traffic against a word-address reference model.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    icache dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        wt;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_data;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    task automatic setv(input int i, input logic ren, input logic [31:0] addr, input logic wt,
                        input logic [31:0] load, input logic e_hit, input logic [31:0] e_data,
                        input logic e_iren, input logic [31:0] e_iaddr,
                        input logic [31:0] e_hc, input logic [31:0] e_mc);
        tbl[i] = '{ren, addr, wt, load, e_hit, e_data, e_iren, e_iaddr, e_hc, e_mc};
    endtask

    // Reference model: each index remembers which word address it holds.
    logic        m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    logic        m_busy;
    logic [29:0] m_addr;
    int          m_hits;
    int          m_misses;

    task automatic apply_reset();
        nRST = 1'b0;
        imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'h1234_5678;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", {31'b0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iren", {31'b0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Cold miss, hit, conflict refill, address change mid-fill.
        setv(0,  1, 32'h40, 1, 32'h0,          0, 32'h0,          0, 32'h0,  0, 0);
        setv(1,  1, 32'h40, 1, 32'h0,          0, 32'h0,          1, 32'h40, 0, 1);
        setv(2,  1, 32'h40, 1, 32'h0,          0, 32'h0,          1, 32'h40, 0, 1);
        setv(3,  1, 32'h40, 0, 32'h0050_0093,  0, 32'h0,          1, 32'h40, 0, 1);
        setv(4,  1, 32'h40, 1, 32'h0,          1, 32'h0050_0093,  0, 32'h0,  0, 1);
        setv(5,  1, 32'h42, 1, 32'h0,          1, 32'h0050_0093,  0, 32'h0,  1, 1);
        setv(6,  1, 32'h80, 1, 32'h0,          0, 32'h0,          0, 32'h0,  2, 1);
        setv(7,  1, 32'h80, 0, 32'hAAAA_0080,  0, 32'h0,          1, 32'h80, 2, 2);
        setv(8,  1, 32'h80, 1, 32'h0,          1, 32'hAAAA_0080,  0, 32'h0,  2, 2);
        setv(9,  1, 32'h40, 0, 32'h0,          0, 32'h0,          0, 32'h0,  3, 2);
        setv(10, 1, 32'h40, 0, 32'h0050_0093,  0, 32'h0,          1, 32'h40, 3, 3);
        setv(11, 1, 32'h40, 1, 32'h0,          1, 32'h0050_0093,  0, 32'h0,  3, 3);
        setv(12, 1, 32'h44, 1, 32'h0,          0, 32'h0,          0, 32'h0,  4, 3);
        setv(13, 1, 32'h48, 1, 32'h0,          0, 32'h0,          1, 32'h44, 4, 4);
        setv(14, 0, 32'h48, 0, 32'h1111_0044,  0, 32'h0,          1, 32'h44, 4, 4);
        setv(15, 1, 32'h48, 1, 32'h0,          0, 32'h0,          0, 32'h0,  4, 4);
        setv(16, 1, 32'h48, 0, 32'h2222_0048,  0, 32'h0,          1, 32'h48, 4, 5);
        setv(17, 1, 32'h44, 1, 32'h0,          1, 32'h1111_0044,  0, 32'h0,  4, 5);
        setv(18, 1, 32'h48, 1, 32'h0,          1, 32'h2222_0048,  0, 32'h0,  5, 5);

        for (int i = 0; i < NVEC; i++) begin
            imemREN = tbl[i].ren; imemaddr = tbl[i].addr;
            iwait = tbl[i].wt;    iload = tbl[i].load;
            @(negedge CLK);
            $display("[TB] row %0d ren=%0b addr=%h iwait=%0b -> ihit=%0b load=%h iREN=%0b iaddr=%h",
                     i, imemREN, imemaddr, iwait, ihit, imemload, iREN, iaddr);
            chk($sformatf("row%0d_ihit", i), {31'b0, ihit}, {31'b0, tbl[i].e_hit});
            chk($sformatf("row%0d_imemload", i), imemload, tbl[i].e_data);
            chk($sformatf("row%0d_iren", i), {31'b0, iREN}, {31'b0, tbl[i].e_iren});
            chk($sformatf("row%0d_iaddr", i), iaddr, tbl[i].e_iaddr);
            chk($sformatf("row%0d_hit_count", i), hit_count, tbl[i].e_hc);
            chk($sformatf("row%0d_miss_count", i), miss_count, tbl[i].e_mc);
            @(posedge CLK);
            #1;
        end

        // Idle: no request for 10 cycles leaves everything unchanged.
        imemREN = 1'b0; imemaddr = 32'h44; iwait = 1'b0; iload = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_ihit", {31'b0, ihit}, 32'h0);
            chk("idle_iren", {31'b0, iREN}, 32'h0);
            @(posedge CLK);
            #1;
        end
        chk("idle_hit_count", hit_count, 32'd6);
        chk("idle_miss_count", miss_count, 32'd5);
        $display("[TB] idle 10 cycles hits=%0d misses=%0d", hit_count, miss_count);

        // Reset in the middle of a fill.
        imemREN = 1'b1; imemaddr = 32'h4C; iwait = 1'b1;
        @(negedge CLK);
        chk("rmf_miss_ihit", {31'b0, ihit}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rmf_fetch_iren", {31'b0, iREN}, 32'h1);
        chk("rmf_fetch_iaddr", iaddr, 32'h4C);
        nRST = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF;
        #1;
        chk("rmf_rst_iren", {31'b0, iREN}, 32'h0);
        chk("rmf_rst_iaddr", iaddr, 32'h0);
        chk("rmf_rst_hit_count", hit_count, 32'h0);
        chk("rmf_rst_miss_count", miss_count, 32'h0);
        @(posedge CLK);
        #1 nRST = 1'b1; iwait = 1'b1;
        @(negedge CLK);
        chk("rmf_after_ihit", {31'b0, ihit}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rmf_after_iren", {31'b0, iREN}, 32'h1);
        chk("rmf_after_miss_count", miss_count, 32'd1);
        iwait = 1'b0; iload = 32'h0C0C_0C0C;
        @(posedge CLK);
        #1 imemaddr = 32'h40;
        @(negedge CLK);
        chk("rmf_valid_cleared_ihit", {31'b0, ihit}, 32'h0);
        $display("[TB] reset mid-fetch sequence done");

        // Randomized traffic against the reference model.
        apply_reset();
        for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        m_busy = 1'b0; m_addr = '0; m_hits = 0; m_misses = 0;
        for (int c = 0; c < 2000; c++) begin
            logic        e_hit;
            logic [31:0] e_data;
            logic [3:0]  ix;
            imemREN  = ($urandom_range(0, 9) < 8);
            imemaddr = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3))};
            iwait    = ($urandom_range(0, 2) != 0);
            iload    = $urandom;
            ix       = imemaddr[5:2];
            e_hit    = !m_busy && imemREN && m_valid[ix] && (m_word[ix] == imemaddr[31:2]);
            e_data   = e_hit ? m_data[ix] : 32'h0;
            @(negedge CLK);
            chk("rand_ihit", {31'b0, ihit}, {31'b0, e_hit});
            chk("rand_imemload", imemload, e_data);
            chk("rand_iren", {31'b0, iREN}, {31'b0, m_busy});
            chk("rand_iaddr", iaddr, m_busy ? {m_addr, 2'b00} : 32'h0);
            if (c % 100 == 0) begin
                chk("rand_hit_count", hit_count, 32'(m_hits));
                chk("rand_miss_count", miss_count, 32'(m_misses));
            end
            if (!m_busy) begin
                if (e_hit) m_hits++;
                else if (imemREN) begin
                    m_busy = 1'b1; m_addr = imemaddr[31:2]; m_misses++;
                end
            end else if (!iwait) begin
                m_valid[m_addr[3:0]] = 1'b1;
                m_word[m_addr[3:0]]  = m_addr;
                m_data[m_addr[3:0]]  = iload;
                m_busy = 1'b0;
                $display("[TB] rand fill addr=%h data=%h", {m_addr, 2'b00}, iload);
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        chk("rand_final_hit_count", hit_count, 32'(m_hits));
        chk("rand_final_miss_count", miss_count, 32'(m_misses));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
